// File: rtl/lane_stripe_tx.sv
// lane_stripe_tx: stripes 64-byte TX beats round-robin across 1/2/4/8/16 lanes of 1/2/4 bytes each
// Ports: clk, reset (sync, active-high); GEN (1/2/3 -> 1/2/4 bytes per lane), LANESNUMBER (1,2,4,8,16);
//   txData/txDataK/txValid in, txReady out; laneData (16 x 32-bit slots), laneDataK (4 bits per slot),
//   laneValid (one bit per lane), cfgError (latched configuration of the last discarded beat was illegal).
// LANE_STRIPE_TX_PINGPONG_EN: two alternating buffers for gapless output; otherwise a single buffer.
module lane_stripe_tx #(
  parameter int GEN1_PIPEWIDTH = 8,
  parameter int MAXLANES = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [2:0]                           GEN,
  input  logic [4:0]                           LANESNUMBER,
  input  logic [511:0]                         txData,
  input  logic [63:0]                          txDataK,
  input  logic                                 txValid,
  output logic                                 txReady,
  output logic [MAXLANES*4*GEN1_PIPEWIDTH-1:0] laneData,
  output logic [MAXLANES*4-1:0]                laneDataK,
  output logic [MAXLANES-1:0]                  laneValid,
  output logic                                 cfgError
);
`ifdef LANE_STRIPE_TX_PINGPONG_EN
  localparam logic PP = 1'b1;
`else
  localparam logic PP = 1'b0;
`endif
  logic [511:0] bufd [2];
  logic [63:0] bufk [2];
  logic [2:0] lsh_q [2];
  logic [1:0] wsh_q [2];
  logic [1:0] bad_q, full;
  logic wr, rd, in_ok, last, drain, discard, acc;
  logic [5:0] idx, base, nm1, src;
  logic [2:0] lsh, in_lsh, sh;
  logic [1:0] wsh, in_wsh;
  logic [511:0] sd;
  logic [63:0] sk;
  logic [MAXLANES*4*GEN1_PIPEWIDTH-1:0] slice_d;
  logic [MAXLANES*4-1:0] slice_k;
  logic [MAXLANES-1:0] lmask;
  assign in_ok = (LANESNUMBER inside {5'd1, 5'd2, 5'd4, 5'd8, 5'd16}) && (GEN inside {3'd1, 3'd2, 3'd3});
  assign in_lsh = LANESNUMBER == 5'd1 ? 3'd0 : LANESNUMBER == 5'd2 ? 3'd1 : LANESNUMBER == 5'd4 ? 3'd2 :
                  LANESNUMBER == 5'd8 ? 3'd3 : 3'd4;
  assign in_wsh = GEN == 3'd3 ? 2'd2 : GEN == 3'd2 ? 2'd1 : 2'd0;
  assign txReady = !reset && !full[wr];
  assign acc = txValid && txReady;
  assign lsh = lsh_q[rd];
  assign wsh = wsh_q[rd];
  assign sh = lsh + 3'(wsh);
  assign base = idx << sh;
  assign nm1 = 6'((7'd64 >> sh) - 7'd1);
  assign last = idx == nm1;
  assign drain = full[rd] && !bad_q[rd];
  assign discard = full[rd] && bad_q[rd];
  assign sd = bufd[rd] >> {base, 3'b000};
  assign sk = bufk[rd] >> base;
  assign lmask = MAXLANES'((32'd1 << (32'd1 << lsh)) - 32'd1);
  // Within a slice, byte n = p*L + k lands in lane k at position p.
  always_comb begin
    src = '0;
    slice_d = '0;
    slice_k = '0;
    for (int k = 0; k < MAXLANES; k++)
      for (int p = 0; p < 4; p++) begin
        src = 6'((p << lsh) + k);
        if ((k >> lsh) == 0 && (p >> wsh) == 0) begin
          slice_d[32*k+8*p +: 8] = sd[8*src +: 8];
          slice_k[4*k+p] = sk[src];
        end
      end
  end
  always_ff @(posedge clk) begin
    if (acc) begin
      bufd[wr] <= txData;
      bufk[wr] <= txDataK;
      lsh_q[wr] <= in_lsh;
      wsh_q[wr] <= in_wsh;
      bad_q[wr] <= !in_ok;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= '0;
      idx <= '0;
      wr <= 1'b0;
      rd <= 1'b0;
      laneData <= '0;
      laneDataK <= '0;
      laneValid <= '0;
      cfgError <= 1'b0;
    end else begin
      laneData <= drain ? slice_d : '0;
      laneDataK <= drain ? slice_k : '0;
      laneValid <= drain ? lmask : '0;
      cfgError <= discard ? 1'b1 : acc && in_ok ? 1'b0 : cfgError;
      idx <= drain && !last ? idx + 6'd1 : '0;
      if (discard || (drain && last)) begin
        full[rd] <= 1'b0;
        rd <= rd ^ PP;
      end
      if (acc) begin
        full[wr] <= 1'b1;
        wr <= wr ^ PP;
      end
    end
  end
endmodule

// File: tb/tb_lane_stripe_tx.sv
// tb_lane_stripe_tx: randomized and directed checks of lane_stripe_tx against a queue-based striping model
module tb_lane_stripe_tx;
`ifdef LANE_STRIPE_TX_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  logic clk = 1'b0;
  logic reset, txValid, txReady, cfgError;
  logic [2:0] GEN;
  logic [4:0] LANESNUMBER;
  logic [511:0] txData, laneData;
  logic [63:0] txDataK, laneDataK;
  logic [15:0] laneValid;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [511:0] d;
    logic [63:0] k;
    int l;
    int w;
    bit ok;
    int j;
  } beat_t;
  beat_t q[$];
  logic [511:0] exp_d, ramp;
  logic [63:0] exp_k;
  logic [15:0] exp_v;
  logic exp_err;
  always #5 clk = ~clk;
  lane_stripe_tx dut (
    .clk(clk), .reset(reset), .GEN(GEN), .LANESNUMBER(LANESNUMBER),
    .txData(txData), .txDataK(txDataK), .txValid(txValid), .txReady(txReady),
    .laneData(laneData), .laneDataK(laneDataK), .laneValid(laneValid), .cfgError(cfgError)
  );
  task automatic check(string tag, logic [511:0] got, logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic bit legal(int g, int l);
    return g >= 1 && g <= 3 && (l == 1 || l == 2 || l == 4 || l == 8 || l == 16);
  endfunction
  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction
  // Drive one cycle's inputs, predict the next edge, then compare the registered outputs.
  task automatic step(bit r, bit v, int g, int l, logic [511:0] d, logic [63:0] k);
    bit rdy, acc, disc;
    beat_t b;
    int byt;
    reset = r;
    txValid = v;
    GEN = 3'(g);
    LANESNUMBER = 5'(l);
    txData = d;
    txDataK = k;
    #1;
    rdy = !r && q.size() < NB;
    check("txReady", txReady, rdy);
    acc = v && rdy;
    disc = 0;
    exp_d = '0;
    exp_k = '0;
    exp_v = '0;
    if (r) begin
      q.delete();
      exp_err = 0;
    end else begin
      if (q.size() > 0) begin
        b = q[0];
        if (!b.ok) begin
          disc = 1;
          void'(q.pop_front());
        end else begin
          for (int ln = 0; ln < b.l; ln++)
            for (int p = 0; p < b.w; p++) begin
              byt = b.j * b.l * b.w + p * b.l + ln;
              exp_d[32*ln+8*p +: 8] = b.d[8*byt +: 8];
              exp_k[4*ln+p] = b.k[byt];
            end
          exp_v = 16'((1 << b.l) - 1);
          b.j++;
          if (b.j == 64 / (b.l * b.w)) void'(q.pop_front());
          else q[0] = b;
        end
      end
      if (acc) begin
        b.d = d;
        b.k = k;
        b.l = l;
        b.w = g == 3 ? 4 : g;
        b.ok = legal(g, l);
        b.j = 0;
        q.push_back(b);
      end
      if (disc) exp_err = 1;
      else if (acc && legal(g, l)) exp_err = 0;
    end
    @(negedge clk);
    check("laneData", laneData, exp_d);
    check("laneDataK", laneDataK, exp_k);
    check("laneValid", laneValid, exp_v);
    check("cfgError", cfgError, exp_err);
  endtask
  initial begin
    int vcnt;
    int g, l;
    for (int i = 0; i < 64; i++) ramp[8*i +: 8] = 8'(i);
    @(negedge clk);
    step(1, 0, 1, 1, '0, '0);
    step(1, 0, 1, 1, '0, '0);
    step(0, 0, 1, 1, '0, '0);
    check("rst_ready", txReady, 1'b1);
    step(0, 1, 1, 8, ramp, '0);
    step(0, 0, 1, 8, ramp, '0);
    check("g1l8_valid", laneValid, 16'h00FF);
    check("g1l8_slot1", laneData[63:32], 32'h1);
    repeat (8) step(0, 0, 1, 8, ramp, '0);
    step(0, 1, 2, 2, ramp, 64'h1);
    step(0, 0, 2, 2, ramp, '0);
    check("g2l2_slot0", laneData[31:0], 32'h0200);
    check("g2l2_slot1", laneData[63:32], 32'h0301);
    check("g2l2_k0", laneDataK, 64'h1);
    step(0, 0, 2, 2, ramp, '0);
    check("g2l2_k1", laneDataK, 64'h0);
    repeat (15) step(0, 0, 2, 2, ramp, '0);
    step(0, 1, 3, 16, ramp, '0);
    step(0, 1, 3, 16, ramp, '0);
    check("g3_slot0", laneData[31:0], 32'h30201000);
    check("g3_valid", laneValid, 16'hFFFF);
    vcnt = 0;
    repeat (10) begin
      step(0, 1, 3, 16, ramp, '0);
      vcnt += int'(laneValid != 0);
    end
    check("g3_stream", vcnt, NB == 2 ? 10 : 5);
    repeat (3) step(0, 0, 3, 16, ramp, '0);
    step(0, 1, 1, 3, ramp, '0);
    step(0, 0, 1, 3, ramp, '0);
    check("bad_err", cfgError, 1'b1);
    check("bad_valid", laneValid, 16'h0);
    step(0, 1, 1, 1, ramp, '0);
    check("bad_clear", cfgError, 1'b0);
    vcnt = 0;
    repeat (66) begin
      step(0, 0, 1, 1, ramp, '0);
      vcnt += int'(laneValid != 0);
    end
    check("l1_slices", vcnt, 64);
    step(0, 1, 1, 1, ramp, '0);
    repeat (5) step(0, 0, 1, 1, ramp, '0);
    step(1, 0, 1, 1, ramp, '0);
    check("rst_mid_valid", laneValid, 16'h0);
    check("rst_mid_err", cfgError, 1'b0);
    step(0, 0, 1, 1, ramp, '0);
    repeat (1500) begin
      g = $urandom_range(0, 15) == 0 ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 3));
      l = $urandom_range(0, 15) == 0 ? int'($urandom_range(0, 31)) : 1 << $urandom_range(0, 4);
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, g, l, rand512(), {$urandom, $urandom});
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
